// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory read port shared by the fetch controller and the
// synchronous instruction memory (one-cycle read latency).
interface if_fetch_ctrl_if;
  logic        rden;
  logic [31:0] addr;
  logic [31:0] data;

  // Fetch side: issues reads, receives data the following cycle.
  modport master (
    output rden,
    output addr,
    input  data
  );

  // Memory side.
  modport slave (
    input  rden,
    input  addr,
    output data
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch requester: owns the fetch PC, drives the instruction
// memory read port, pairs each returned word with its PC, absorbs decode
// stalls with a one-entry hold buffer and restarts on EX redirects.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   stall_i,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_pc_i,
  if_fetch_ctrl_if.master        imem,
  output logic                   valid_o,
  output logic [31:0]            instr_o,
  output logic [31:0]            pc_o
);

  logic        run_q,         run_d;
  logic [31:0] fetch_pc_q,    fetch_pc_d;
  logic        inflight_q,    inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        hold_valid_q,  hold_valid_d;
  logic [31:0] hold_instr_q,  hold_instr_d;
  logic [31:0] hold_pc_q,     hold_pc_d;

  logic        slot_valid;
  logic        out_valid;
  logic        consume;
  logic        issue;
  logic [31:0] issue_addr;

  // Output-slot occupancy and request decision for this cycle.
  always_comb begin
    slot_valid = hold_valid_q | inflight_q;
    out_valid  = slot_valid & ~redirect_i;
    consume    = out_valid & ~stall_i;
    issue      = run_q & (redirect_i | ~(out_valid & stall_i));
    issue_addr = redirect_i ? {redirect_pc_i[31:2], 2'b00} : fetch_pc_q;
  end

  // Next-state: request tracking, PC advance, hold-buffer capture/release.
  always_comb begin
    run_d         = 1'b1;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    hold_valid_d  = hold_valid_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;

    if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = issue_addr;
      fetch_pc_d    = issue_addr + 32'd4;
    end

    // Redirect outranks stall; the live response is captured only while the
    // hold buffer is empty, since memory data is valid for one cycle only.
    if (redirect_i) begin
      hold_valid_d = 1'b0;
    end else if (out_valid && stall_i && !hold_valid_q) begin
      hold_valid_d = 1'b1;
      hold_instr_d = imem.data;
      hold_pc_d    = inflight_pc_q;
    end else if (consume) begin
      hold_valid_d = 1'b0;
    end
  end

  // State registers, asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q         <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      hold_valid_q  <= 1'b0;
      hold_instr_q  <= '0;
      hold_pc_q     <= '0;
    end else begin
      run_q         <= run_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      hold_valid_q  <= hold_valid_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc_q     <= hold_pc_d;
    end
  end

  // Memory request and IF/ID presentation; held word wins over live data.
  always_comb begin
    imem.rden = issue;
    imem.addr = issue_addr;
    valid_o   = out_valid;
    instr_o   = NOP_INSTR;
    pc_o      = '0;
    if (out_valid) begin
      instr_o = hold_valid_q ? hold_instr_q : imem.data;
      pc_o    = hold_valid_q ? hold_pc_q    : inflight_pc_q;
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: streaming, stall hold, redirect,
// redirect during stall, address wrap and mid-stream reset.
module tb_if_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;

  int checks   = 0;
  int failures = 0;

  if_fetch_ctrl_if imem_bus ();

  if_fetch_ctrl #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem          (imem_bus.master),
    .valid_o       (valid),
    .instr_o       (instr),
    .pc_o          (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: mem[i] = 0x1000_0000 + i; garbage when not read.
  always @(posedge clk) begin
    if (imem_bus.rden)
      imem_bus.data <= 32'h1000_0000 + {18'b0, imem_bus.addr[15:2]};
    else
      imem_bus.data <= 32'hDEAD_BEEF;
  end

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (instr !== 32'h0000_0013) begin failures++; $display("FAIL reset_instr: got %h expected 00000013", instr); end
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h expected 00000000", pc); end
    checks++; if (imem_bus.rden !== 1'b0) begin failures++; $display("FAIL reset_rden: got %b expected 0", imem_bus.rden); end
    checks++; if (imem_bus.addr !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h expected 00000000", imem_bus.addr); end
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (imem_bus.rden !== 1'b1) begin failures++; $display("FAIL first_req_rden: got %b expected 1", imem_bus.rden); end
    checks++; if (imem_bus.addr !== 32'h0) begin failures++; $display("FAIL first_req_addr: got %h expected 00000000", imem_bus.addr); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL first_req_valid: got %b expected 0", valid); end
    @(negedge clk); #1;
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL first_valid: got %b expected 1", valid); end
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL first_pc: got %h expected 00000000", pc); end
    checks++; if (instr !== 32'h1000_0000) begin failures++; $display("FAIL first_instr: got %h expected 10000000", instr); end
    checks++; if (imem_bus.addr !== 32'h4) begin failures++; $display("FAIL first_next_addr: got %h expected 00000004", imem_bus.addr); end
  endtask

  task automatic test_stream();
    @(negedge clk); #1;
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL stream_valid: got %b expected 1", valid); end
    checks++; if (pc !== 32'h4) begin failures++; $display("FAIL stream_pc: got %h expected 00000004", pc); end
    checks++; if (instr !== 32'h1000_0001) begin failures++; $display("FAIL stream_instr: got %h expected 10000001", instr); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stall = 1'b1;
      #1;
      checks++; if (valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, valid); end
      checks++; if (pc !== 32'h8) begin failures++; $display("FAIL stall_pc[%0d]: got %h expected 00000008", i, pc); end
      checks++; if (instr !== 32'h1000_0002) begin failures++; $display("FAIL stall_instr[%0d]: got %h expected 10000002", i, instr); end
      if (i > 0) begin
        checks++; if (imem_bus.rden !== 1'b0) begin failures++; $display("FAIL stall_rden[%0d]: got %b expected 0", i, imem_bus.rden); end
      end
    end
    @(negedge clk);
    stall = 1'b0;
    #1;
    checks++; if (pc !== 32'h8) begin failures++; $display("FAIL unstall_pc: got %h expected 00000008", pc); end
    checks++; if (instr !== 32'h1000_0002) begin failures++; $display("FAIL unstall_instr: got %h expected 10000002", instr); end
    checks++; if (imem_bus.rden !== 1'b1) begin failures++; $display("FAIL unstall_rden: got %b expected 1", imem_bus.rden); end
    checks++; if (imem_bus.addr !== 32'hC) begin failures++; $display("FAIL unstall_addr: got %h expected 0000000c", imem_bus.addr); end
    @(negedge clk); #1;
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL after_stall_valid: got %b expected 1", valid); end
    checks++; if (pc !== 32'hC) begin failures++; $display("FAIL after_stall_pc: got %h expected 0000000c", pc); end
    checks++; if (instr !== 32'h1000_0003) begin failures++; $display("FAIL after_stall_instr: got %h expected 10000003", instr); end
  endtask

  task automatic test_redirect();
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0040;
    #1;
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL redir_valid: got %b expected 0", valid); end
    checks++; if (instr !== 32'h0000_0013) begin failures++; $display("FAIL redir_instr: got %h expected 00000013", instr); end
    checks++; if (imem_bus.rden !== 1'b1) begin failures++; $display("FAIL redir_rden: got %b expected 1", imem_bus.rden); end
    checks++; if (imem_bus.addr !== 32'h40) begin failures++; $display("FAIL redir_addr: got %h expected 00000040", imem_bus.addr); end
    @(negedge clk);
    redirect = 1'b0;
    #1;
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL redir_tgt_valid: got %b expected 1", valid); end
    checks++; if (pc !== 32'h40) begin failures++; $display("FAIL redir_tgt_pc: got %h expected 00000040", pc); end
    checks++; if (instr !== 32'h1000_0010) begin failures++; $display("FAIL redir_tgt_instr: got %h expected 10000010", instr); end
    @(negedge clk); #1;
    checks++; if (pc !== 32'h44) begin failures++; $display("FAIL redir_next_pc: got %h expected 00000044", pc); end
    checks++; if (instr !== 32'h1000_0011) begin failures++; $display("FAIL redir_next_instr: got %h expected 10000011", instr); end
  endtask

  task automatic test_redirect_stall();
    @(negedge clk);
    stall = 1'b1;
    #1;
    checks++; if (pc !== 32'h48) begin failures++; $display("FAIL rs_cap_pc: got %h expected 00000048", pc); end
    @(negedge clk); #1;
    checks++; if (pc !== 32'h48) begin failures++; $display("FAIL rs_hold_pc: got %h expected 00000048", pc); end
    checks++; if (instr !== 32'h1000_0012) begin failures++; $display("FAIL rs_hold_instr: got %h expected 10000012", instr); end
    checks++; if (imem_bus.rden !== 1'b0) begin failures++; $display("FAIL rs_hold_rden: got %b expected 0", imem_bus.rden); end
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0080;
    #1;
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rs_redir_valid: got %b expected 0", valid); end
    checks++; if (imem_bus.rden !== 1'b1) begin failures++; $display("FAIL rs_redir_rden: got %b expected 1", imem_bus.rden); end
    checks++; if (imem_bus.addr !== 32'h80) begin failures++; $display("FAIL rs_redir_addr: got %h expected 00000080", imem_bus.addr); end
    @(negedge clk);
    redirect = 1'b0;
    stall = 1'b0;
    #1;
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL rs_tgt_valid: got %b expected 1", valid); end
    checks++; if (pc !== 32'h80) begin failures++; $display("FAIL rs_tgt_pc: got %h expected 00000080", pc); end
    checks++; if (instr !== 32'h1000_0020) begin failures++; $display("FAIL rs_tgt_instr: got %h expected 10000020", instr); end
    @(negedge clk); #1;
    checks++; if (pc !== 32'h84) begin failures++; $display("FAIL rs_next_pc: got %h expected 00000084", pc); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    #1;
    checks++; if (imem_bus.addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr: got %h expected fffffffc", imem_bus.addr); end
    checks++; if (imem_bus.rden !== 1'b1) begin failures++; $display("FAIL wrap_rden: got %b expected 1", imem_bus.rden); end
    @(negedge clk);
    redirect = 1'b0;
    #1;
    checks++; if (pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc: got %h expected fffffffc", pc); end
    checks++; if (instr !== 32'h1000_3FFF) begin failures++; $display("FAIL wrap_instr: got %h expected 10003fff", instr); end
    checks++; if (imem_bus.addr !== 32'h0) begin failures++; $display("FAIL wrap_next_addr: got %h expected 00000000", imem_bus.addr); end
    @(negedge clk); #1;
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL wrap_next_pc: got %h expected 00000000", pc); end
    checks++; if (instr !== 32'h1000_0000) begin failures++; $display("FAIL wrap_next_instr: got %h expected 10000000", instr); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid: got %b expected 0", valid); end
    checks++; if (instr !== 32'h0000_0013) begin failures++; $display("FAIL mid_rst_instr: got %h expected 00000013", instr); end
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL mid_rst_pc: got %h expected 00000000", pc); end
    checks++; if (imem_bus.rden !== 1'b0) begin failures++; $display("FAIL mid_rst_rden: got %b expected 0", imem_bus.rden); end
    checks++; if (imem_bus.addr !== 32'h0) begin failures++; $display("FAIL mid_rst_addr: got %h expected 00000000", imem_bus.addr); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (imem_bus.rden !== 1'b1) begin failures++; $display("FAIL restart_rden: got %b expected 1", imem_bus.rden); end
    checks++; if (imem_bus.addr !== 32'h0) begin failures++; $display("FAIL restart_addr: got %h expected 00000000", imem_bus.addr); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL restart_req_valid: got %b expected 0", valid); end
    @(negedge clk); #1;
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL restart_pc0: got %h expected 00000000", pc); end
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL restart_valid: got %b expected 1", valid); end
    @(negedge clk); #1;
    checks++; if (pc !== 32'h4) begin failures++; $display("FAIL restart_pc4: got %h expected 00000004", pc); end
    checks++; if (instr !== 32'h1000_0001) begin failures++; $display("FAIL restart_instr4: got %h expected 10000001", instr); end
  endtask

  initial begin
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
